// File: rtl/sccb_target.sv
// sccb_target: SCCB/I2C target emulating the OV7670 register port.
// Oversamples SCL/SDA, holds a 256x8 regfile, answers reads via sda_oe.
module sccb_target #(
  parameter logic [6:0] DEV_ID = 7'h21,
  parameter logic       ACK_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       wr_valid,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy,
  input  logic [7:0] dbg_addr,
  output logic [7:0] dbg_data
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_ID        = 4'd1;
  localparam logic [3:0] S_ID_ACK    = 4'd2;
  localparam logic [3:0] S_SUB       = 4'd3;
  localparam logic [3:0] S_SUB_ACK   = 4'd4;
  localparam logic [3:0] S_WR        = 4'd5;
  localparam logic [3:0] S_WR_ACK    = 4'd6;
  localparam logic [3:0] S_RD        = 4'd7;
  localparam logic [3:0] S_RD_ACK    = 4'd8;
  localparam logic [3:0] S_IGNORE    = 4'd9;
  localparam logic [3:0] S_WAIT_STOP = 4'd10;

  logic       scl_s1, scl_s2, scl_s3;
  logic       sda_s1, sda_s2, sda_s3;
  logic       scl_rise, scl_fall;
  logic       start_ev, stop_ev;
  logic       sda_bit;
  logic [3:0] state;
  logic [3:0] bit_cnt;
  logic [7:0] shreg;
  logic [7:0] tx;
  logic [7:0] sub_addr;
  logic       ack_on;
  logic       rd_mode;
  logic [7:0] byte_in;
  logic       last_bit;
  logic       rx_state;
  logic [7:0] regfile [256];

  assign byte_in  = {shreg[6:0], sda_bit};
  assign last_bit = (bit_cnt == 4'd7);
  assign rx_state = (state == S_ID) ||
                    (state == S_SUB) ||
                    (state == S_WR);
  assign dbg_data = regfile[dbg_addr];

  // two-flop synchronizers plus a history flop; idle bus reads as high
  always_ff @(posedge clk) begin
    if (reset) begin
      {scl_s1, scl_s2, scl_s3} <= 3'b111;
      {sda_s1, sda_s2, sda_s3} <= 3'b111;
    end else begin
      {scl_s1, scl_s2, scl_s3} <= {scl, scl_s1, scl_s2};
      {sda_s1, sda_s2, sda_s3} <= {sda_in, sda_s1, sda_s2};
    end
  end

  // registered line events and the SDA value seen with them
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_rise <= 1'b0;
      scl_fall <= 1'b0;
      start_ev <= 1'b0;
      stop_ev  <= 1'b0;
      sda_bit  <= 1'b1;
    end else begin
      scl_rise <= scl_s2 & ~scl_s3;
      scl_fall <= ~scl_s2 & scl_s3;
      start_ev <= scl_s2 & scl_s3 & sda_s3 & ~sda_s2;
      stop_ev  <= scl_s2 & scl_s3 & ~sda_s3 & sda_s2;
      sda_bit  <= sda_s2;
    end
  end

  // protocol FSM: START/STOP override, then per-state bit handling
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      bit_cnt  <= 4'd0;
      shreg    <= 8'h00;
      tx       <= 8'h00;
      sub_addr <= 8'h00;
      sda_oe   <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= 8'h00;
      wr_data  <= 8'h00;
      busy     <= 1'b0;
      ack_on   <= 1'b0;
      rd_mode  <= 1'b0;
    end else begin
      wr_valid <= 1'b0;
      if (start_ev) begin
        state   <= S_ID;
        bit_cnt <= 4'd0;
        sda_oe  <= 1'b0;
        ack_on  <= 1'b0;
      end else if (stop_ev) begin
        state   <= S_IDLE;
        bit_cnt <= 4'd0;
        sda_oe  <= 1'b0;
        ack_on  <= 1'b0;
        busy    <= 1'b0;
      end else begin
        if (scl_rise && rx_state) begin
          shreg   <= byte_in;
          bit_cnt <= bit_cnt + 4'd1;
        end
        case (state)
          S_ID: begin
            if (scl_rise && last_bit) begin
              if (byte_in[7:1] == DEV_ID) begin
                state   <= S_ID_ACK;
                rd_mode <= byte_in[0];
                busy    <= 1'b1;
              end else begin
                state <= S_IGNORE;
              end
            end
          end
          S_SUB: begin
            if (scl_rise && last_bit) begin
              sub_addr <= byte_in;
              state    <= S_SUB_ACK;
            end
          end
          S_WR: begin
            if (scl_rise && last_bit) begin
              wr_valid <= 1'b1;
              wr_addr  <= sub_addr;
              wr_data  <= byte_in;
              sub_addr <= sub_addr + 8'd1;
              state    <= S_WR_ACK;
            end
          end
          S_ID_ACK, S_SUB_ACK, S_WR_ACK: begin
            if (scl_fall) begin
              if (!ack_on) begin
                sda_oe <= ACK_EN;
                ack_on <= 1'b1;
              end else begin
                ack_on  <= 1'b0;
                bit_cnt <= 4'd0;
                if (state == S_ID_ACK && rd_mode) begin
                  tx     <= regfile[sub_addr];
                  sda_oe <= ~regfile[sub_addr][7];
                  state  <= S_RD;
                end else begin
                  sda_oe <= 1'b0;
                  state  <= (state == S_ID_ACK) ?
                            S_SUB : S_WR;
                end
              end
            end
          end
          S_RD: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end
            if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe <= 1'b0;
                state  <= S_RD_ACK;
              end else begin
                tx     <= {tx[6:0], 1'b0};
                sda_oe <= ~tx[6];
              end
            end
          end
          S_RD_ACK: begin
            if (scl_rise) begin
              sub_addr <= sub_addr + 8'd1;
              if (sda_bit) begin
                state <= S_WAIT_STOP;
              end else begin
                ack_on <= 1'b1;
              end
            end
            if (scl_fall && ack_on) begin
              ack_on  <= 1'b0;
              bit_cnt <= 4'd0;
              tx      <= regfile[sub_addr];
              sda_oe  <= ~regfile[sub_addr][7];
              state   <= S_RD;
            end
          end
          default: begin
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

  // register file, written one cycle behind the wr_valid strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) begin
        regfile[i] <= 8'h00;
      end
    end else if (wr_valid) begin
      regfile[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_sccb_target.sv
// tb_sccb_target: bus-level master model for sccb_target.
// Write/read scoreboards plus a per-scenario task sequence.
module tb_sccb_target;

  logic       clk = 1'b0;
  logic       reset;
  logic       scl;
  logic       sda_m;
  logic       sda_line;
  logic       sda_oe;
  logic       wr_valid;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic [7:0] dbg_addr;
  logic [7:0] dbg_data;

  int errors   = 0;
  int checks   = 0;
  int wr_count = 0;

  logic [15:0] exp_wr[$];
  logic [7:0]  exp_rd[$];
  logic [7:0]  model [256];
  logic        mon_oe  = 1'b0;
  logic        oe_seen = 1'b0;
  logic        prev_wv = 1'b0;

  assign sda_line = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  sccb_target dut (
    .clk      (clk),
    .reset    (reset),
    .scl      (scl),
    .sda_in   (sda_line),
    .sda_oe   (sda_oe),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // write scoreboard and pulse-width watch
  always @(negedge clk) begin
    logic [15:0] exp;
    if (mon_oe && sda_oe) oe_seen = 1'b1;
    if (!reset && wr_valid) begin
      wr_count++;
      checks++;
      if (prev_wv) begin
        errors++;
        $display("FAIL wr_width: wr_valid high 2+ cycles");
      end
      checks++;
      if (exp_wr.size() == 0) begin
        errors++;
        $display("FAIL wr_extra: got %h=%h, required none",
                 wr_addr, wr_data);
      end else begin
        exp = exp_wr.pop_front();
        if ({wr_addr, wr_data} !== exp) begin
          errors++;
          $display("FAIL wr_data: got %h=%h, required %h=%h",
                   wr_addr, wr_data, exp[15:8], exp[7:0]);
        end
      end
    end
    prev_wv = wr_valid;
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_bit(input logic b, output logic r);
    clks(5);
    sda_m = b;
    clks(5);
    scl = 1'b1;
    clks(5);
    r = sda_line;
    clks(5);
    scl = 1'b0;
  endtask

  task automatic start_cond();
    if (!scl) begin
      clks(5);
      sda_m = 1'b1;
      clks(5);
      scl = 1'b1;
    end
    clks(5);
    sda_m = 1'b0;
    clks(5);
    scl = 1'b0;
  endtask

  task automatic stop_cond();
    clks(5);
    sda_m = 1'b0;
    clks(5);
    scl = 1'b1;
    clks(5);
    sda_m = 1'b1;
    clks(10);
  endtask

  task automatic send_byte(input logic [7:0] b,
                           output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], r);
    bus_bit(1'b1, ack);
  endtask

  task automatic send_bits(input logic [7:0] b,
                           input int n);
    logic r;
    for (int i = 7; i > 7 - n; i--) bus_bit(b[i], r);
  endtask

  task automatic recv_byte(input logic nack,
                           output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, r);
      d[i] = r;
    end
    bus_bit(nack, r);
  endtask

  task automatic queue_wr(input logic [7:0] a,
                          input logic [7:0] d);
    exp_wr.push_back({a, d});
    model[a] = d;
  endtask

  task automatic test_reset();
    logic bad;
    reset    = 1'b1;
    scl      = 1'b1;
    sda_m    = 1'b1;
    dbg_addr = 8'h00;
    for (int i = 0; i < 256; i++) model[i] = 8'h00;
    clks(4);
    reset = 1'b0;
    clks(2);
    checks++;
    if ({sda_oe, wr_valid, busy, wr_addr, wr_data}
        !== 19'h0) begin
      errors++;
      $display("FAIL reset_out: got %b%b%b %h %h, required 0",
               sda_oe, wr_valid, busy, wr_addr, wr_data);
    end
    bad = 1'b0;
    for (int i = 0; i < 256; i++) begin
      dbg_addr = i[7:0];
      #1;
      if (dbg_data !== 8'h00) bad = 1'b1;
    end
    clks(1);
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL reset_regs: nonzero entry, required 00");
    end
  endtask

  task automatic test_write();
    logic [2:0] a;
    logic       b;
    int         w0 = wr_count;
    queue_wr(8'h3A, 8'h04);
    start_cond();
    send_byte(8'h42, a[0]);
    b = busy;
    send_byte(8'h3A, a[1]);
    send_byte(8'h04, a[2]);
    stop_cond();
    checks++;
    if (a !== 3'b000) begin
      errors++;
      $display("FAIL wr_acks: got %b, required 000", a);
    end
    checks++;
    if (b !== 1'b1) begin
      errors++;
      $display("FAIL wr_busy: got %b, required 1", b);
    end
    checks++;
    if (wr_count - w0 != 1) begin
      errors++;
      $display("FAIL wr_pulses: got %0d, required 1",
               wr_count - w0);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wr_busy_end: got %b, required 0", busy);
    end
    dbg_addr = 8'h3A;
    clks(1);
    checks++;
    if (dbg_data !== 8'h04) begin
      errors++;
      $display("FAIL wr_dbg: got %h, required 04", dbg_data);
    end
  endtask

  task automatic test_burst();
    logic [4:0] a;
    int         w0 = wr_count;
    queue_wr(8'hFE, 8'h11);
    queue_wr(8'hFF, 8'h22);
    queue_wr(8'h00, 8'h33);
    start_cond();
    send_byte(8'h42, a[0]);
    send_byte(8'hFE, a[1]);
    send_byte(8'h11, a[2]);
    send_byte(8'h22, a[3]);
    send_byte(8'h33, a[4]);
    stop_cond();
    checks++;
    if (a !== 5'b0 || wr_count - w0 != 3) begin
      errors++;
      $display("FAIL burst: acks %b pulses %0d, required 0 3",
               a, wr_count - w0);
    end
    for (int i = 0; i < 3; i++) begin
      dbg_addr = 8'hFE + i[7:0];
      clks(1);
      checks++;
      if (dbg_data !== model[dbg_addr]) begin
        errors++;
        $display("FAIL burst_dbg %h: got %h, required %h",
                 dbg_addr, dbg_data, model[dbg_addr]);
      end
    end
  endtask

  task automatic test_read();
    logic [3:0] a;
    logic [7:0] d;
    logic [7:0] e;
    int         w0;
    queue_wr(8'h12, 8'hA5);
    queue_wr(8'h13, 8'h3C);
    start_cond();
    send_byte(8'h42, a[0]);
    send_byte(8'h12, a[1]);
    send_byte(8'hA5, a[2]);
    send_byte(8'h3C, a[3]);
    stop_cond();
    w0 = wr_count;
    start_cond();
    send_byte(8'h42, a[0]);
    send_byte(8'h12, a[1]);
    stop_cond();
    start_cond();
    send_byte(8'h43, a[2]);
    exp_rd.push_back(model[8'h12]);
    recv_byte(1'b1, d);
    e = exp_rd.pop_front();
    checks++;
    if (d !== e) begin
      errors++;
      $display("FAIL rd_byte: got %h, required %h", d, e);
    end
    checks++;
    if ({a[2:0], sda_oe, busy} !== 5'b00001) begin
      errors++;
      $display("FAIL rd_na: ack %b oe %b busy %b, req 000 0 1",
               a[2:0], sda_oe, busy);
    end
    stop_cond();
    checks++;
    if (busy !== 1'b0 || wr_count != w0) begin
      errors++;
      $display("FAIL rd_end: busy %b writes %0d, required 0 0",
               busy, wr_count - w0);
    end
    start_cond();
    send_byte(8'h42, a[0]);
    send_byte(8'h12, a[1]);
    start_cond();
    send_byte(8'h43, a[2]);
    exp_rd.push_back(model[8'h12]);
    exp_rd.push_back(model[8'h13]);
    for (int i = 0; i < 2; i++) begin
      recv_byte(i == 1, d);
      e = exp_rd.pop_front();
      checks++;
      if (d !== e) begin
        errors++;
        $display("FAIL rd_burst%0d: got %h, required %h",
                 i, d, e);
      end
    end
    stop_cond();
  endtask

  task automatic test_wrong_id();
    logic [2:0] a;
    int         w0 = wr_count;
    oe_seen = 1'b0;
    mon_oe  = 1'b1;
    start_cond();
    send_byte(8'h44, a[0]);
    send_byte(8'h12, a[1]);
    send_byte(8'h80, a[2]);
    stop_cond();
    mon_oe = 1'b0;
    checks++;
    if (a !== 3'b111 || oe_seen !== 1'b0) begin
      errors++;
      $display("FAIL bad_id: acks %b oe %b, required 111 0",
               a, oe_seen);
    end
    dbg_addr = 8'h12;
    clks(1);
    checks++;
    if (wr_count != w0 || dbg_data !== model[8'h12]) begin
      errors++;
      $display("FAIL bad_id_reg: %0d wr, %h, required 0 %h",
               wr_count - w0, dbg_data, model[8'h12]);
    end
  endtask

  task automatic test_abort();
    logic [2:0] a;
    int         w0 = wr_count;
    start_cond();
    send_byte(8'h42, a[0]);
    send_byte(8'h20, a[1]);
    send_bits(8'hFF, 4);
    stop_cond();
    dbg_addr = 8'h20;
    clks(1);
    checks++;
    if (wr_count != w0 || dbg_data !== 8'h00 || busy) begin
      errors++;
      $display("FAIL abort: %0d wr %h busy %b, required 0 00 0",
               wr_count - w0, dbg_data, busy);
    end
    queue_wr(8'h30, 8'h77);
    start_cond();
    send_byte(8'h42, a[0]);
    send_bits(8'h55, 4);
    start_cond();
    send_byte(8'h42, a[0]);
    send_byte(8'h30, a[1]);
    send_byte(8'h77, a[2]);
    stop_cond();
    dbg_addr = 8'h30;
    clks(1);
    checks++;
    if (a !== 3'b000 || dbg_data !== 8'h77 ||
        wr_count != w0 + 1) begin
      errors++;
      $display("FAIL rstart: acks %b dbg %h, required 000 77",
               a, dbg_data);
    end
  endtask

  task automatic test_reset_mid_read();
    logic [2:0] a;
    logic       oe;
    logic       bz;
    logic       bad;
    queue_wr(8'h40, 8'h3C);
    start_cond();
    send_byte(8'h42, a[0]);
    send_byte(8'h40, a[1]);
    send_byte(8'h3C, a[2]);
    stop_cond();
    start_cond();
    send_byte(8'h42, a[0]);
    send_byte(8'h40, a[1]);
    stop_cond();
    start_cond();
    send_byte(8'h43, a[2]);
    clks(7);
    oe = sda_oe;
    bz = busy;
    checks++;
    if (a !== 3'b000 || oe !== 1'b1 || bz !== 1'b1) begin
      errors++;
      $display("FAIL rd_drive: ack %b oe %b busy %b, req 000 1 1",
               a, oe, bz);
    end
    reset = 1'b1;
    clks(1);
    checks++;
    if ({sda_oe, busy, wr_valid} !== 3'b000) begin
      errors++;
      $display("FAIL rst_mid: oe %b busy %b wv %b, required 000",
               sda_oe, busy, wr_valid);
    end
    bad = 1'b0;
    for (int i = 0; i < 256; i++) begin
      dbg_addr = i[7:0];
      #1;
      if (dbg_data !== 8'h00) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL rst_mid_regs: nonzero entry, required 00");
    end
    scl   = 1'b1;
    sda_m = 1'b1;
    for (int i = 0; i < 256; i++) model[i] = 8'h00;
    clks(3);
    reset = 1'b0;
    clks(5);
  endtask

  task automatic test_back_to_back();
    logic [2:0] a;
    queue_wr(8'h05, 8'h99);
    start_cond();
    send_byte(8'h42, a[0]);
    send_byte(8'h05, a[1]);
    send_byte(8'h99, a[2]);
    stop_cond();
    dbg_addr = 8'h05;
    clks(1);
    checks++;
    if (a !== 3'b000 || dbg_data !== 8'h99) begin
      errors++;
      $display("FAIL post_rst: acks %b dbg %h, required 000 99",
               a, dbg_data);
    end
    checks++;
    if (exp_wr.size() != 0) begin
      errors++;
      $display("FAIL wr_missing: %0d left, required 0",
               exp_wr.size());
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_burst();
    test_read();
    test_wrong_id();
    test_abort();
    test_reset_mid_read();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sccb_target.md
# sccb_target

SCCB/I2C target (responder) that emulates the OV7670 register interface on the camera side of the SCCB bus. It oversamples the open-drain SCL/SDA lines with the system clock and decodes 3-phase write and 2-phase-write-plus-read transactions. It holds a 256x8 register file and returns read data by driving SDA low. It serves as a loopback partner for the camera-configuration master in board bring-up and as the slave model in bench verification.

## Interface
- DEV_ID, 7'h21, 7-bit device ID; write address byte = {DEV_ID,0} = 8'h42, read = 8'h43
- ACK_EN, 1, 1 = drive ACK (SDA low) in the 9th bit of accepted bytes; 0 = leave don't-care bit released
- clk  input  1  system clock; must be ≥ 16× SCL frequency
- reset  input  1  synchronous, active-high
- scl  input  1  SCL line, asynchronous to clk
- sda_in  input  1  sampled SDA line, asynchronous to clk
- sda_oe  output  1  1 = pull SDA low; 0 = release
- wr_valid  output  1  one-cycle pulse per register written
- wr_addr  output  8  register address of the write, valid with wr_valid
- wr_data  output  8  register data of the write, valid with wr_valid
- busy  output  1  high from a START addressed to DEV_ID until STOP
- dbg_addr  input  8  debug read address
- dbg_data  output  8  regfile[dbg_addr], combinational

## Operation
- scl and sda_in each pass a 2-flop synchronizer; a third flop gives the previous value for edge detection.
- START = synced SDA falls while synced SCL is high. STOP = synced SDA rises while SCL is high. Both are checked every clk in every state.
- Data bits are sampled on the synced SCL rising edge, MSB first. sda_oe changes only on the synced SCL falling edge, START, or STOP.
- Bit counter 0..8, where bit 8 is the 9th (ack/don't-care) bit.
- States and transitions:
  - IDLE: START → ID.
  - ID: after 8 bits:
    - {DEV_ID,0} → ID_ACK, then SUB.
    - {DEV_ID,1} → ID_ACK, then RD.
    - Any other value → IGNORE.
  - SUB: after 8 bits → latch sub_addr → SUB_ACK → WR.
  - WR: after 8 bits:
    - regfile[sub_addr] ← byte.
    - wr_valid pulses with wr_addr = sub_addr and wr_data = byte.
    - sub_addr increments → WR_ACK → WR. This allows multi-byte bursts.
  - RD: shift out regfile[sub_addr]. The byte is loaded at the SCL falling edge ending ID_ACK or the previous 9th bit. sda_oe = ~bit.
  - RD 9th bit: release SDA and sample the master's bit. sub_addr increments.
    - Sampled 0 (ACK) → RD with the next byte.
    - Sampled 1 (NA) → WAIT_STOP.
  - IGNORE / WAIT_STOP: sda_oe = 0; wait for STOP or START.
- START seen in any state (repeated start) → ID, with bit counter = 0 and sda_oe = 0. sub_addr is kept, which supports the write-sub-address-then-read sequence.
- STOP seen in any state → IDLE, with sda_oe = 0. A partial byte is discarded and nothing is written.
- ACK states drive sda_oe = ACK_EN for the 9th bit. SDA is released on the SCL falling edge that ends the 9th bit.
- sub_addr is 8 bits and wraps 8'hFF → 8'h00.
- The regfile write port and the dbg_data read port are independent. A write becomes visible on dbg_data the cycle after wr_valid.

## Timing
- Reset values:
  - Outputs: sda_oe 0, wr_valid 0, wr_addr 8'h00, wr_data 8'h00, busy 0.
  - Internal: state IDLE, sub_addr 8'h00, all regfile entries 8'h00. Synchronizer flops reset to 1, meaning the bus is idle.
- Line-event detection latency: 3 clk after the pin change (2 sync flops plus the edge compare).
- wr_valid is asserted in the clk cycle after the SCL-rise detection of data bit 0. It is exactly 1 cycle wide.
- sda_oe update: 1 clk after the SCL-fall detection. This is 4 clk after the actual pin edge, which stays well inside the SCL low phase at 16× oversampling.
- busy rises 1 clk after the ID_ACK decision and falls 1 clk after STOP detection.
- Reset asserted mid-transaction: next cycle is IDLE with sda_oe 0 and the regfile cleared. The bus is ignored until the next START.

## Test plan
- Write 42/3A/04 → wr_valid one pulse with wr_addr 8'h3A, wr_data 8'h04; ACK (sda_oe=1) in all three 9th bits; dbg_addr 3A → dbg_data 04.
- Burst 42/FE/11/22/33 → three writes: FE=11, FF=22, 00=33 (wrap); three wr_valid pulses.
- Write 42/12, STOP, then START 43 with master NA → target shifts out the value of reg 12, MSB first; SDA released after NA; busy low after STOP.
- Wrong ID 44/12/80 → no ACK, no wr_valid, sda_oe 0 for the whole transaction, regfile unchanged.
- STOP after 4 data bits of byte 3 → no write, IDLE; repeated START mid-SUB → restarts ID decode, and a following full write succeeds.
- Assert reset during RD while sda_oe=1 → sda_oe 0 next cycle, regfile all 00, busy 0.
